// File: rtl/proc_pkg.sv
// Shared types and constants for the 8-bit accumulator processor control path.
package proc_pkg;

  // IR opcode field encodings.
  typedef enum logic [2:0] {
    OP_LOAD  = 3'b000,
    OP_STORE = 3'b001,
    OP_ADD   = 3'b010,
    OP_SUB   = 3'b011,
    OP_BNE   = 3'b100,
    OP_BRA   = 3'b101,
    OP_NOP   = 3'b110,
    OP_HALT  = 3'b111
  } opcode_t;

  // Sequencer states: fetch (F0..F2), decode, operand read, execute,
  // store (WR, WR1) and the terminal halt state.
  typedef enum logic [3:0] {
    F0,
    F1,
    F2,
    DEC,
    RD,
    EX,
    WR,
    WR1,
    HALT
  } seq_state_t;

  // Default memory wait limit, in cycles.
  localparam int unsigned TIMEOUT_DEFAULT = 15;

  // True for states that strobe memory and wait on mem_ready.
  function automatic logic is_wait_state(input seq_state_t s);
    return (s == F1) || (s == RD) || (s == WR1);
  endfunction

endpackage

// File: rtl/sequencer_wait_timer.sv
// Memory wait timer: counts stalled cycles and flags when the limit is hit.
module wait_timer
  import proc_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clock,
  input  logic n_reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] count;

  // Count enabled cycles, holding at the limit; clear has priority.
  always_ff @(posedge clock) begin
    if (!n_reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/sequencer.sv
// Control-unit sequencer: fetch/decode/execute with memory handshake and
// wait-timeout. Control strobes are decoded combinationally from the state.
module sequencer
  import proc_pkg::*;
#(
  parameter int unsigned WORD_W  = 8,
  parameter int unsigned OP_W    = 3,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic            clock,
  input  logic            n_reset,
  input  logic [OP_W-1:0] op,
  input  logic            z_flag,
  input  logic            mem_ready,
  output logic            PC_bus,
  output logic            load_PC,
  output logic            INC_PC,
  output logic            load_MAR,
  output logic            load_MDR,
  output logic            MDR_bus,
  output logic            load_IR,
  output logic            Addr_bus,
  output logic            ACC_bus,
  output logic            load_ACC,
  output logic            ALU_ACC,
  output logic            ALU_add,
  output logic            ALU_sub,
  output logic            CS,
  output logic            R_NW,
  output logic            halted,
  output logic            bus_error
);

  if (OP_W != $bits(opcode_t)) begin : g_bad_op_w
    $error("sequencer: OP_W must equal the IR opcode field width");
  end
  if (WORD_W <= OP_W) begin : g_bad_word_w
    $error("sequencer: WORD_W must be wider than the opcode field");
  end
  if ((TIMEOUT < 1) || (TIMEOUT > 255)) begin : g_bad_timeout
    $error("sequencer: TIMEOUT must lie in 1..255");
  end

  seq_state_t state;
  seq_state_t state_nxt;
  opcode_t    opc;
  logic       waiting;
  logic       timer_clear;
  logic       timer_enable;
  logic       expired;
  logic       timeout_hit;

  assign opc          = opcode_t'(op);
  assign waiting      = is_wait_state(state);
  // Outside the wait states the timer is held clear, so each entry starts at 0.
  assign timer_clear  = !waiting || mem_ready;
  assign timer_enable = waiting && !mem_ready;

  wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .clock  (clock),
    .n_reset(n_reset),
    .clear  (timer_clear),
    .enable (timer_enable),
    .expired(expired)
  );

  // Next-state selection, including the timeout escape from wait states.
  always_comb begin
    state_nxt   = state;
    timeout_hit = 1'b0;
    case (state)
      F0: state_nxt = F1;
      F1: begin
        if (mem_ready) begin
          state_nxt = F2;
        end else if (expired) begin
          state_nxt   = HALT;
          timeout_hit = 1'b1;
        end
      end
      F2: state_nxt = DEC;
      DEC: begin
        case (opc)
          OP_LOAD, OP_ADD, OP_SUB: state_nxt = RD;
          OP_STORE:                state_nxt = WR;
          OP_BNE, OP_BRA, OP_NOP:  state_nxt = F0;
          OP_HALT:                 state_nxt = HALT;
          default:                 state_nxt = F0;
        endcase
      end
      RD: begin
        if (mem_ready) begin
          state_nxt = EX;
        end else if (expired) begin
          state_nxt   = HALT;
          timeout_hit = 1'b1;
        end
      end
      EX: state_nxt = F0;
      WR: state_nxt = WR1;
      WR1: begin
        if (mem_ready) begin
          state_nxt = F0;
        end else if (expired) begin
          state_nxt   = HALT;
          timeout_hit = 1'b1;
        end
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = F0;
    endcase
  end

  // Control strobe decode; everything is forced low while reset is held.
  always_comb begin
    PC_bus   = 1'b0;
    load_PC  = 1'b0;
    INC_PC   = 1'b0;
    load_MAR = 1'b0;
    load_MDR = 1'b0;
    MDR_bus  = 1'b0;
    load_IR  = 1'b0;
    Addr_bus = 1'b0;
    ACC_bus  = 1'b0;
    load_ACC = 1'b0;
    ALU_ACC  = 1'b0;
    ALU_add  = 1'b0;
    ALU_sub  = 1'b0;
    CS       = 1'b0;
    R_NW     = 1'b0;
    if (n_reset) begin
      case (state)
        F0: begin
          PC_bus   = 1'b1;
          load_MAR = 1'b1;
        end
        F1: begin
          CS   = 1'b1;
          R_NW = 1'b1;
          if (mem_ready) begin
            load_MDR = 1'b1;
            load_PC  = 1'b1;
            INC_PC   = 1'b1;
          end
        end
        F2: begin
          MDR_bus = 1'b1;
          load_IR = 1'b1;
        end
        DEC: begin
          case (opc)
            OP_LOAD, OP_ADD, OP_SUB, OP_STORE: begin
              Addr_bus = 1'b1;
              load_MAR = 1'b1;
            end
            OP_BNE: begin
              if (!z_flag) begin
                Addr_bus = 1'b1;
                load_PC  = 1'b1;
              end
            end
            OP_BRA: begin
              Addr_bus = 1'b1;
              load_PC  = 1'b1;
            end
            default: ;
          endcase
        end
        RD: begin
          CS   = 1'b1;
          R_NW = 1'b1;
          if (mem_ready) begin
            load_MDR = 1'b1;
          end
        end
        EX: begin
          MDR_bus  = 1'b1;
          load_ACC = 1'b1;
          case (opc)
            OP_ADD: begin
              ALU_ACC = 1'b1;
              ALU_add = 1'b1;
            end
            OP_SUB: begin
              ALU_ACC = 1'b1;
              ALU_sub = 1'b1;
            end
            default: ;
          endcase
        end
        WR: begin
          ACC_bus  = 1'b1;
          load_MDR = 1'b1;
        end
        WR1: begin
          CS = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // State register and sticky status flags.
  always_ff @(posedge clock) begin
    if (!n_reset) begin
      state     <= F0;
      halted    <= 1'b0;
      bus_error <= 1'b0;
    end else begin
      state  <= state_nxt;
      halted <= (state_nxt == HALT);
      if (timeout_hit) begin
        bus_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sequencer.sv
// Directed bench for the sequencer: per-cycle checks of every control output
// and status flag against hand-derived patterns.
module tb_sequencer;

  logic       clock;
  logic       n_reset;
  logic [2:0] op;
  logic       z_flag;
  logic       mem_ready;
  logic PC_bus, load_PC, INC_PC, load_MAR, load_MDR, MDR_bus, load_IR, Addr_bus;
  logic ACC_bus, load_ACC, ALU_ACC, ALU_add, ALU_sub, CS, R_NW, halted, bus_error;

  int n_tests  = 0;
  int n_fail   = 0;
  int bus_chk  = 0;
  int bus_fail = 0;

  // Observed vector: {bus_error, halted, 15 control strobes}
  localparam logic [16:0] B_BUSERR = 17'h10000;
  localparam logic [16:0] B_HALTED = 17'h08000;
  localparam logic [16:0] B_PCBUS  = 17'h04000;
  localparam logic [16:0] B_LDPC   = 17'h02000;
  localparam logic [16:0] B_INC    = 17'h01000;
  localparam logic [16:0] B_LDMAR  = 17'h00800;
  localparam logic [16:0] B_LDMDR  = 17'h00400;
  localparam logic [16:0] B_MDRBUS = 17'h00200;
  localparam logic [16:0] B_LDIR   = 17'h00100;
  localparam logic [16:0] B_ADDR   = 17'h00080;
  localparam logic [16:0] B_ACCBUS = 17'h00040;
  localparam logic [16:0] B_LDACC  = 17'h00020;
  localparam logic [16:0] B_ALUACC = 17'h00010;
  localparam logic [16:0] B_ADD    = 17'h00008;
  localparam logic [16:0] B_SUB    = 17'h00004;
  localparam logic [16:0] B_CS     = 17'h00002;
  localparam logic [16:0] B_RNW    = 17'h00001;

  localparam logic [16:0] E_ZERO = 17'h00000;
  localparam logic [16:0] E_F0   = B_PCBUS | B_LDMAR;
  localparam logic [16:0] E_F1W  = B_CS | B_RNW;
  localparam logic [16:0] E_F1   = B_CS | B_RNW | B_LDMDR | B_LDPC | B_INC;
  localparam logic [16:0] E_F2   = B_MDRBUS | B_LDIR;
  localparam logic [16:0] E_DECM = B_ADDR | B_LDMAR;
  localparam logic [16:0] E_BR   = B_ADDR | B_LDPC;
  localparam logic [16:0] E_RDW  = B_CS | B_RNW;
  localparam logic [16:0] E_RD   = B_CS | B_RNW | B_LDMDR;
  localparam logic [16:0] E_EXL  = B_MDRBUS | B_LDACC;
  localparam logic [16:0] E_EXA  = B_MDRBUS | B_LDACC | B_ALUACC | B_ADD;
  localparam logic [16:0] E_EXS  = B_MDRBUS | B_LDACC | B_ALUACC | B_SUB;
  localparam logic [16:0] E_WR   = B_ACCBUS | B_LDMDR;
  localparam logic [16:0] E_WR1  = B_CS;
  localparam logic [16:0] E_HLT  = B_HALTED;
  localparam logic [16:0] E_TMO  = B_HALTED | B_BUSERR;

  logic [16:0] obs;
  assign obs = {bus_error, halted, PC_bus, load_PC, INC_PC, load_MAR, load_MDR,
                MDR_bus, load_IR, Addr_bus, ACC_bus, load_ACC, ALU_ACC, ALU_add,
                ALU_sub, CS, R_NW};

  sequencer #(
    .WORD_W (8),
    .OP_W   (3),
    .TIMEOUT(15)
  ) dut (
    .clock    (clock),
    .n_reset  (n_reset),
    .op       (op),
    .z_flag   (z_flag),
    .mem_ready(mem_ready),
    .PC_bus   (PC_bus),
    .load_PC  (load_PC),
    .INC_PC   (INC_PC),
    .load_MAR (load_MAR),
    .load_MDR (load_MDR),
    .MDR_bus  (MDR_bus),
    .load_IR  (load_IR),
    .Addr_bus (Addr_bus),
    .ACC_bus  (ACC_bus),
    .load_ACC (load_ACC),
    .ALU_ACC  (ALU_ACC),
    .ALU_add  (ALU_add),
    .ALU_sub  (ALU_sub),
    .CS       (CS),
    .R_NW     (R_NW),
    .halted   (halted),
    .bus_error(bus_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // At most one bus driver at any time.
  always @(negedge clock) begin
    bus_chk++;
    assert ($countones({PC_bus, MDR_bus, ACC_bus, Addr_bus}) <= 1) else begin
      bus_fail++;
      $error("FAIL bus_contention: drivers=%b required at most one",
             {PC_bus, MDR_bus, ACC_bus, Addr_bus});
    end
  end

  // Check the current cycle's outputs, then advance one clock.
  task automatic cyc(input string tag, input logic [16:0] exp);
    #1;
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %05h expected %05h", tag, obs, exp);
    end
    @(negedge clock);
  endtask

  task automatic fetch(input string tag);
    mem_ready = 1'b1;
    cyc({tag, "_f0"}, E_F0);
    cyc({tag, "_f1"}, E_F1);
    cyc({tag, "_f2"}, E_F2);
  endtask

  initial begin
    n_reset   = 1'b0;
    op        = 3'b001;
    z_flag    = 1'b0;
    mem_ready = 1'b0;
    @(negedge clock);
    cyc("reset_a", E_ZERO);
    cyc("reset_b", E_ZERO);

    // NOP: F0 F1 F2 DEC
    n_reset = 1'b1;
    op      = 3'b110;
    fetch("nop");
    cyc("nop_dec", E_ZERO);

    // LOAD with two RD wait cycles: 8 cycles total
    fetch("load");
    op = 3'b000;
    cyc("load_dec", E_DECM);
    mem_ready = 1'b0;
    cyc("load_rdw1", E_RDW);
    cyc("load_rdw2", E_RDW);
    mem_ready = 1'b1;
    cyc("load_rd", E_RD);
    cyc("load_ex", E_EXL);

    // ADD, zero wait
    fetch("add");
    op = 3'b010;
    cyc("add_dec", E_DECM);
    cyc("add_rd", E_RD);
    cyc("add_ex", E_EXA);

    // SUB with one fetch wait cycle
    cyc("sub_f0", E_F0);
    mem_ready = 1'b0;
    cyc("sub_f1w", E_F1W);
    mem_ready = 1'b1;
    cyc("sub_f1", E_F1);
    cyc("sub_f2", E_F2);
    op = 3'b011;
    cyc("sub_dec", E_DECM);
    cyc("sub_rd", E_RD);
    cyc("sub_ex", E_EXS);

    // STORE: mem_ready ignored in WR, write strobe in WR1
    fetch("st");
    op = 3'b001;
    cyc("st_dec", E_DECM);
    mem_ready = 1'b0;
    cyc("st_wr", E_WR);
    mem_ready = 1'b1;
    cyc("st_wr1", E_WR1);

    // BNE taken / not taken, BRA ignores z_flag
    fetch("bne0");
    op     = 3'b100;
    z_flag = 1'b0;
    cyc("bne0_dec", E_BR);
    fetch("bne1");
    z_flag = 1'b1;
    cyc("bne1_dec", E_ZERO);
    fetch("bra");
    op = 3'b101;
    cyc("bra_dec", E_BR);
    z_flag = 1'b0;

    // NOP with mem_ready low outside wait states
    op = 3'b110;
    cyc("nopi_f0", E_F0);
    cyc("nopi_f1", E_F1);
    mem_ready = 1'b0;
    cyc("nopi_f2", E_F2);
    cyc("nopi_dec", E_ZERO);

    // Ready arrives in the last permitted wait cycle: no timeout
    cyc("resc_f0", E_F0);
    for (int i = 0; i < 15; i++) cyc("resc_f1w", E_F1W);
    mem_ready = 1'b1;
    cyc("resc_f1", E_F1);
    cyc("resc_f2", E_F2);
    cyc("resc_dec", E_ZERO);

    // Stuck mem_ready: 16 cycles in F1, then HALT with bus_error
    cyc("tmo_f0", E_F0);
    mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) cyc("tmo_f1w", E_F1W);
    cyc("tmo_halt", E_TMO);
    mem_ready = 1'b1;
    op        = 3'b000;
    cyc("tmo_hold1", E_TMO);
    cyc("tmo_hold2", E_TMO);

    // Reset clears the sticky flags at the edge
    n_reset = 1'b0;
    cyc("tmo_rst_pre", E_TMO & ~E_ZERO & (B_HALTED | B_BUSERR));
    cyc("tmo_rst_post", E_ZERO);
    n_reset = 1'b1;

    // Reset during WR1, restart with HALT
    op = 3'b001;
    fetch("rw");
    cyc("rw_dec", E_DECM);
    cyc("rw_wr", E_WR);
    mem_ready = 1'b0;
    cyc("rw_wr1", E_WR1);
    n_reset = 1'b0;
    cyc("rw_rst", E_ZERO);
    n_reset = 1'b1;
    op      = 3'b111;
    cyc("rs_f0_nocs", E_F0);
    mem_ready = 1'b1;
    cyc("rs_f1", E_F1);
    cyc("rs_f2", E_F2);
    cyc("rs_dec", E_ZERO);
    cyc("rs_halt", E_HLT);
    cyc("rs_hold", E_HLT);

    $display("[TB] %0d tests run, %0d failed", n_tests + bus_chk, n_fail + bus_fail);
    $finish;
  end

endmodule
